// File: rtl/tile_spawn_scheduler.sv
// tile_spawn_scheduler
//   Queues per-lane tile spawn requests and offers them one at a time to the
//   tile renderer, spacing accepted spawns by a speed-dependent gap.
//
// Ports
//   Clk          system clock, rising edge
//   Reset        synchronous, active-high reset
//   enable       game active; low flushes the queue and idles the FSM
//   block_req    [3:0] per-lane spawn request pulses (bit i = lane i)
//   speed        [3:0] difficulty level, sampled on the handshake edge
//   pause        suspends new offers and freezes the gap counter
//   spawn_valid  a spawn is offered to the renderer
//   spawn_lane   [1:0] lane of the offered spawn (0 when not valid)
//   spawn_ready  renderer accepts the offer
//   queue_count  [3:0] current queue occupancy
//   overflow     sticky, a request was dropped (cleared only by Reset)
//   busy         FSM is outside IDLE
module tile_spawn_scheduler #(
    parameter int DEPTH    = 8,
    parameter int BASE_GAP = 48,
    parameter int MIN_GAP  = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic [3:0] block_req,
    input  logic [3:0] speed,
    input  logic       pause,
    output logic       spawn_valid,
    output logic [1:0] spawn_lane,
    input  logic       spawn_ready,
    output logic [3:0] queue_count,
    output logic       overflow,
    output logic       busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = PW + 3;

    typedef enum logic [2:0] {IDLE, READY, OFFER, GAP, PAUSED} state_t;

    state_t        state, state_nx;
    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, wr_nx, rd_inc;
    logic [PW-1:0] wr_idx [4];
    logic [3:0]    count;
    logic [15:0]   gap_cnt, gap_cnt_nx, gap_load;
    logic signed [15:0] gap_s;
    logic          overflow_r;
    logic          pop;

    // Request acceptance: lanes are taken in ascending order against the
    // free space seen before this edge's pop, so a pop never frees a slot
    // for a same-edge request.
    logic [3:0]    free;
    logic [2:0]    n_acc;
    logic [1:0]    acc_lane [4];
    logic          drop;

    always_comb begin
        free  = 4'(DEPTH) - count;
        n_acc = '0;
        drop  = 1'b0;
        for (int unsigned i = 0; i < 4; i++) acc_lane[i] = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (enable && block_req[i]) begin
                if ({1'b0, n_acc} < free) begin
                    acc_lane[n_acc[1:0]] = 2'(i);
                    n_acc                = n_acc + 3'd1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    // Ring-buffer write slots; indices only matter for slots below n_acc,
    // which never exceed 2*DEPTH so one wrap subtraction suffices.
    always_comb begin
        logic [AW-1:0] sum;
        for (int unsigned j = 0; j < 4; j++) begin
            sum = AW'(wr_ptr) + AW'(j);
            if (sum >= AW'(DEPTH)) sum = sum - AW'(DEPTH);
            wr_idx[j] = PW'(sum);
        end
        sum = AW'(wr_ptr) + AW'(n_acc);
        if (sum >= AW'(DEPTH)) sum = sum - AW'(DEPTH);
        wr_nx  = PW'(sum);
        rd_inc = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end

    always_comb begin
        gap_s = 16'(BASE_GAP) - 16'({speed, 2'b00});
        if (gap_s < $signed(16'(MIN_GAP))) gap_s = 16'(MIN_GAP);
        gap_load = 16'(gap_s) - 16'd1;
    end

    assign pop = (state == OFFER) && spawn_ready && enable;

    always_comb begin
        state_nx   = state;
        gap_cnt_nx = gap_cnt;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:   state_nx = READY;
                READY: begin
                    if (pause)              state_nx = PAUSED;
                    else if (count != '0)   state_nx = OFFER;
                end
                OFFER: begin
                    if (spawn_ready) begin
                        state_nx   = GAP;
                        gap_cnt_nx = gap_load;
                    end
                end
                GAP: begin
                    if (!pause) begin
                        if (gap_cnt == '0) state_nx   = READY;
                        else               gap_cnt_nx = gap_cnt - 16'd1;
                    end
                end
                PAUSED: if (!pause) state_nx = READY;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            gap_cnt    <= '0;
            overflow_r <= 1'b0;
        end else begin
            state   <= state_nx;
            gap_cnt <= gap_cnt_nx;
            if (!enable) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                for (int unsigned j = 0; j < 4; j++) begin
                    if (3'(j) < n_acc) mem[wr_idx[j]] <= acc_lane[j];
                end
                wr_ptr <= wr_nx;
                if (pop) rd_ptr <= rd_inc;
                count <= count + {1'b0, n_acc} - {3'b000, pop};
                if (drop) overflow_r <= 1'b1;
            end
        end
    end

    assign spawn_valid = (state == OFFER);
    assign spawn_lane  = spawn_valid ? mem[rd_ptr] : '0;
    assign queue_count = count;
    assign overflow    = overflow_r;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_tile_spawn_scheduler.sv
// tb_tile_spawn_scheduler
//   Directed bench for tile_spawn_scheduler (default parameters).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_tile_spawn_scheduler;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       enable;
    logic [3:0] block_req;
    logic [3:0] speed;
    logic       pause;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic       spawn_ready;
    logic [3:0] queue_count;
    logic       overflow;
    logic       busy;

    int total = 0;
    int bad   = 0;

    tile_spawn_scheduler #(.DEPTH(8), .BASE_GAP(48), .MIN_GAP(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .enable      (enable),
        .block_req   (block_req),
        .speed       (speed),
        .pause       (pause),
        .spawn_valid (spawn_valid),
        .spawn_lane  (spawn_lane),
        .spawn_ready (spawn_ready),
        .queue_count (queue_count),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic reset_start();
        Reset       = 1'b1;
        enable      = 1'b0;
        block_req   = '0;
        spawn_ready = 1'b0;
        pause       = 1'b0;
        step();
        Reset  = 1'b0;
        enable = 1'b1;
        step();
    endtask

    // Counts edges until spawn_valid is seen, bounded by budget.
    task automatic wait_valid(input string tag, input int budget, output int edges);
        edges = 0;
        while (!spawn_valid && edges < budget) begin
            step();
            edges++;
        end
        chk({tag, "_valid"}, spawn_valid, 1);
    endtask

    // Waits for the next offer, checks its distance from the previous
    // handshake and its lane, then completes the handshake.
    task automatic offer_next(input string tag, input logic [1:0] exp_lane, input int exp_edges);
        int e;
        wait_valid(tag, 200, e);
        chk({tag, "_edges"}, e, exp_edges);
        chk({tag, "_lane"}, spawn_lane, exp_lane);
        spawn_ready = 1'b1;
        step();
        chk({tag, "_pop"}, spawn_valid, 0);
    endtask

    initial begin
        int e;
        logic [1:0] lanes9 [9];
        logic [1:0] drain [8];
        lanes9 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        drain  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        speed  = 4'd0;

        // Reset state and single pulse latency
        Reset = 1'b1; enable = 1'b1; block_req = 4'b1111; spawn_ready = 1'b1; pause = 1'b0;
        step();
        chk("rst_count", queue_count, 0);
        chk("rst_valid", spawn_valid, 0);
        chk("rst_lane", spawn_lane, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        reset_start();
        chk("t1_busy", busy, 1);
        spawn_ready = 1'b1;
        block_req   = 4'b0100;
        step();
        block_req = '0;
        chk("t1_cnt1", queue_count, 1);
        chk("t1_nv", spawn_valid, 0);
        step();
        chk("t1_valid", spawn_valid, 1);
        chk("t1_lane", spawn_lane, 2);
        step();
        chk("t1_hs_valid", spawn_valid, 0);
        chk("t1_hs_cnt", queue_count, 0);

        // Multi-lane pulse, held offer, same-edge enqueue+pop
        reset_start();
        speed     = 4'd15;
        block_req = 4'b1011;
        step();
        block_req = '0;
        chk("t2_cnt", queue_count, 3);
        wait_valid("t2a", 10, e);
        chk("t2a_edges", e, 1);
        chk("t2a_lane", spawn_lane, 0);
        step(3);
        chk("t2_hold_valid", spawn_valid, 1);
        chk("t2_hold_lane", spawn_lane, 0);
        spawn_ready = 1'b1;
        block_req   = 4'b0100;
        step();
        block_req = '0;
        chk("t2_enqpop_cnt", queue_count, 3);
        offer_next("t2b", 2'd1, 5);
        offer_next("t2c", 2'd3, 5);
        offer_next("t2d", 2'd2, 5);
        chk("t2_empty", queue_count, 0);

        // Overflow with nine single-lane pulses
        reset_start();
        speed = 4'd15;
        for (int i = 0; i < 9; i++) begin
            block_req = 4'b0001 << lanes9[i];
            step();
        end
        block_req = '0;
        chk("t3_cnt", queue_count, 8);
        chk("t3_ovf", overflow, 1);
        chk("t3_valid", spawn_valid, 1);
        chk("t3_lane0", spawn_lane, drain[0]);
        // Pop while full: the same-edge request sees no free space.
        spawn_ready = 1'b1;
        block_req   = 4'b0001;
        step();
        block_req = '0;
        chk("t3_full_pop_cnt", queue_count, 7);
        for (int i = 1; i < 8; i++) offer_next($sformatf("t3_d%0d", i), drain[i], 5);
        chk("t3_empty", queue_count, 0);
        enable = 1'b0;
        step();
        chk("t3_idle_busy", busy, 0);
        chk("t3_ovf_sticky", overflow, 1);

        // Speed-dependent gap and clamp
        reset_start();
        speed     = 4'd5;
        block_req = 4'b0111;
        step();
        block_req = '0;
        wait_valid("t4a", 10, e);
        chk("t4a_lane", spawn_lane, 0);
        spawn_ready = 1'b1;
        step();
        speed = 4'd15;
        offer_next("t4b", 2'd1, 29);
        offer_next("t4c", 2'd2, 5);

        // Pause mid-gap and during an offer
        reset_start();
        speed     = 4'd10;
        block_req = 4'b0011;
        step();
        block_req = '0;
        wait_valid("t5a", 10, e);
        chk("t5a_lane", spawn_lane, 0);
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        step(3);
        pause = 1'b1;
        step(10);
        chk("t5_paused_nv", spawn_valid, 0);
        pause = 1'b0;
        wait_valid("t5b", 100, e);
        chk("t5b_edges", e, 6);
        chk("t5b_lane", spawn_lane, 1);
        pause = 1'b1;
        step(3);
        chk("t5_offer_held", spawn_valid, 1);
        chk("t5_offer_lane", spawn_lane, 1);
        spawn_ready = 1'b1;
        step();
        chk("t5_hs_valid", spawn_valid, 0);
        chk("t5_hs_cnt", queue_count, 0);
        pause = 1'b0;

        // Disable during offer, then Reset mid-gap
        reset_start();
        block_req = 4'b1111;
        step();
        block_req = 4'b0001;
        step();
        block_req = '0;
        chk("t6_cnt5", queue_count, 5);
        chk("t6_valid", spawn_valid, 1);
        enable = 1'b0;
        step();
        chk("t6_dis_valid", spawn_valid, 0);
        chk("t6_dis_cnt", queue_count, 0);
        chk("t6_dis_busy", busy, 0);
        block_req = 4'b1111;
        step();
        chk("t6_ignored", queue_count, 0);
        enable = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        block_req = '0;
        chk("t6_ovf", overflow, 1);
        spawn_ready = 1'b1;
        step();
        chk("t6_gap_cnt", queue_count, 7);
        step(2);
        Reset     = 1'b1;
        block_req = 4'b1111;
        step();
        chk("t6_rst_cnt", queue_count, 0);
        chk("t6_rst_valid", spawn_valid, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_lane", spawn_lane, 0);
        Reset = 1'b0; enable = 1'b0; block_req = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
